// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with a held index, direct load and
// prescaled up/down auto-scan; out is decoded from registers only.
module scan_decoder #(
  parameter int SEL_W      = 3,
  parameter int DIV        = 1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        in,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        idx,
  output logic                    valid,
  output logic                    wrap
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PS_LAST = PW'(DIV - 1);
  localparam logic [SEL_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {
    HOLD    = 2'b00,
    LOAD    = 2'b01,
    SCAN_UP = 2'b10,
    SCAN_DN = 2'b11
  } mode_t;

  logic [SEL_W-1:0] idx_r;
  logic             valid_r;
  logic             wrap_r;
  logic [PW-1:0]    ps_r;
  mode_t            last_mode_r;
  mode_t            mode_s;
  logic [OUT_W-1:0] raw_s;

  function automatic logic [OUT_W-1:0] decode(input logic v, input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] one;
    one = {{(OUT_W-1){1'b0}}, 1'b1};
    if (v) begin
      decode = one << i;
    end else begin
      decode = {OUT_W{1'b0}};
    end
  endfunction

  assign mode_s = mode_t'(mode);

  // Index, validity, prescaler and wrap-pulse state update.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r       <= {SEL_W{1'b0}};
      valid_r     <= 1'b0;
      wrap_r      <= 1'b0;
      ps_r        <= {PW{1'b0}};
      last_mode_r <= HOLD;
    end else if (!en) begin
      wrap_r <= 1'b0;
    end else begin
      last_mode_r <= mode_s;
      wrap_r      <= 1'b0;
      case (mode_s)
        HOLD: begin
          ps_r <= {PW{1'b0}};
        end
        LOAD: begin
          idx_r   <= in;
          valid_r <= 1'b1;
          ps_r    <= {PW{1'b0}};
        end
        SCAN_UP, SCAN_DN: begin
          valid_r <= 1'b1;
          // Mode entry and first activation both show the held index before stepping.
          if ((mode_s != last_mode_r) || !valid_r) begin
            ps_r <= {PW{1'b0}};
          end else if (ps_r == PS_LAST) begin
            ps_r <= {PW{1'b0}};
            if (mode_s == SCAN_UP) begin
              idx_r  <= idx_r + SEL_W'(1);
              wrap_r <= (idx_r == IDX_MAX);
            end else begin
              idx_r  <= idx_r - SEL_W'(1);
              wrap_r <= (idx_r == {SEL_W{1'b0}});
            end
          end else begin
            ps_r <= ps_r + PW'(1);
          end
        end
        default: begin
          ps_r <= {PW{1'b0}};
        end
      endcase
    end
  end

  // Output polarity selection on the decoded index.
  always_comb begin
    raw_s = decode(valid_r, idx_r);
    if (ACTIVE_LOW) begin
      out = ~raw_s;
    end else begin
      out = raw_s;
    end
  end

  assign idx   = idx_r;
  assign valid = valid_r;
  assign wrap  = wrap_r;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: three instances (DIV=1, DIV=3, active-low
// 4-bit); directed vectors push expectations, a monitor pops and compares.
module tb_scan_decoder;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_LOAD = 2'b01;
  localparam logic [1:0] M_UP   = 2'b10;
  localparam logic [1:0] M_DN   = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic en_a, en_b, en_c;
  logic [1:0] mode_a, mode_b, mode_c;
  logic [2:0] in_a, in_b;
  logic [3:0] in_c;
  logic [7:0]  out_a, out_b;
  logic [15:0] out_c;
  logic [2:0]  idx_a, idx_b;
  logic [3:0]  idx_c;
  logic valid_a, valid_b, valid_c, wrap_a, wrap_b, wrap_c;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          id;
    logic [3:0]  idx;
    logic        v;
    logic        w;
    logic [15:0] o;
    string       nm;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(3), .DIV(1), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .in(in_a),
    .out(out_a), .idx(idx_a), .valid(valid_a), .wrap(wrap_a));

  scan_decoder #(.SEL_W(3), .DIV(3), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .in(in_b),
    .out(out_b), .idx(idx_b), .valid(valid_b), .wrap(wrap_b));

  scan_decoder #(.SEL_W(4), .DIV(1), .ACTIVE_LOW(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .mode(mode_c), .in(in_c),
    .out(out_c), .idx(idx_c), .valid(valid_c), .wrap(wrap_c));

  task automatic chk(input string nm, input string f, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%h exp=%h", nm, f, act, exp);
    end
  endtask

  // Drive one cycle of stimulus to instance id and queue its expected state after the edge.
  task automatic cyc(input int id, input logic r, input logic e, input logic [1:0] m,
                     input logic [3:0] i, input logic [3:0] eidx, input logic ev,
                     input logic ew, input logic [15:0] eo, input string nm);
    exp_t x;
    @(negedge clk);
    rst    = r;
    en_a   = (id == 0) ? e : 1'b0;
    en_b   = (id == 1) ? e : 1'b0;
    en_c   = (id == 2) ? e : 1'b0;
    mode_a = m; mode_b = m; mode_c = m;
    in_a   = i[2:0]; in_b = i[2:0]; in_c = i;
    x.id = id; x.idx = eidx; x.v = ev; x.w = ew; x.o = eo; x.nm = nm;
    sb.push_back(x);
  endtask

  // Monitor: compare the selected instance against the oldest queued expectation.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.id)
        0: begin
          chk(x.nm, "idx", {13'd0, idx_a}, x.idx);
          chk(x.nm, "valid", {15'd0, valid_a}, {15'd0, x.v});
          chk(x.nm, "wrap", {15'd0, wrap_a}, {15'd0, x.w});
          chk(x.nm, "out", {8'd0, out_a}, x.o);
        end
        1: begin
          chk(x.nm, "idx", {13'd0, idx_b}, x.idx);
          chk(x.nm, "valid", {15'd0, valid_b}, {15'd0, x.v});
          chk(x.nm, "wrap", {15'd0, wrap_b}, {15'd0, x.w});
          chk(x.nm, "out", {8'd0, out_b}, x.o);
        end
        default: begin
          chk(x.nm, "idx", {12'd0, idx_c}, x.idx);
          chk(x.nm, "valid", {15'd0, valid_c}, {15'd0, x.v});
          chk(x.nm, "wrap", {15'd0, wrap_c}, {15'd0, x.w});
          chk(x.nm, "out", out_c, x.o);
        end
      endcase
    end
  end

  initial begin
    rst = 1'b1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    mode_a = M_HOLD; mode_b = M_HOLD; mode_c = M_HOLD;
    in_a = 3'd0; in_b = 3'd0; in_c = 4'd0;

    // Instance A: reset then free-running scan up
    cyc(0, 1'b1, 1'b1, M_UP, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, "rst0");
    cyc(0, 1'b1, 1'b1, M_UP, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, "rst1");
    cyc(0, 1'b0, 1'b1, M_UP, 4'd0, 4'd0, 1'b1, 1'b0, 16'h0001, "first_act");
    for (int k = 1; k < 8; k++) begin
      cyc(0, 1'b0, 1'b1, M_UP, 4'd0, 4'(k), 1'b1, 1'b0, 16'h0001 << k, "scan_up");
    end
    cyc(0, 1'b0, 1'b1, M_UP, 4'd0, 4'd0, 1'b1, 1'b1, 16'h0001, "up_wrap");
    cyc(0, 1'b0, 1'b1, M_UP, 4'd0, 4'd1, 1'b1, 1'b0, 16'h0002, "up_after_wrap");

    // Load latency, back-to-back loads
    cyc(0, 1'b0, 1'b1, M_LOAD, 4'd5, 4'd5, 1'b1, 1'b0, 16'h0020, "load5");
    cyc(0, 1'b0, 1'b1, M_LOAD, 4'd2, 4'd2, 1'b1, 1'b0, 16'h0004, "load2");

    // Scan down and direction switch
    cyc(0, 1'b0, 1'b1, M_LOAD, 4'd1, 4'd1, 1'b1, 1'b0, 16'h0002, "load1");
    cyc(0, 1'b0, 1'b1, M_DN, 4'd0, 4'd1, 1'b1, 1'b0, 16'h0002, "dn_entry");
    cyc(0, 1'b0, 1'b1, M_DN, 4'd0, 4'd0, 1'b1, 1'b0, 16'h0001, "dn_1to0");
    cyc(0, 1'b0, 1'b1, M_DN, 4'd0, 4'd7, 1'b1, 1'b1, 16'h0080, "dn_wrap");
    cyc(0, 1'b0, 1'b1, M_UP, 4'd0, 4'd7, 1'b1, 1'b0, 16'h0080, "switch_up_hold");
    cyc(0, 1'b0, 1'b1, M_UP, 4'd0, 4'd0, 1'b1, 1'b1, 16'h0001, "switch_up_wrap");

    // Load beats a due step; reset beats load; invalid survives HOLD
    cyc(0, 1'b0, 1'b1, M_LOAD, 4'd3, 4'd3, 1'b1, 1'b0, 16'h0008, "load_beats_step");
    cyc(0, 1'b1, 1'b1, M_LOAD, 4'd7, 4'd0, 1'b0, 1'b0, 16'h0000, "rst_beats_load");
    cyc(0, 1'b0, 1'b1, M_HOLD, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, "hold_invalid");

    // Instance B (DIV=3): prescaled stepping with an enable gap
    cyc(1, 1'b0, 1'b1, M_LOAD, 4'd6, 4'd6, 1'b1, 1'b0, 16'h0040, "b_load6");
    cyc(1, 1'b0, 1'b1, M_UP, 4'd0, 4'd6, 1'b1, 1'b0, 16'h0040, "b_entry");
    cyc(1, 1'b0, 1'b1, M_UP, 4'd0, 4'd6, 1'b1, 1'b0, 16'h0040, "b_ps1");
    cyc(1, 1'b0, 1'b1, M_UP, 4'd0, 4'd6, 1'b1, 1'b0, 16'h0040, "b_ps2");
    cyc(1, 1'b0, 1'b1, M_UP, 4'd0, 4'd7, 1'b1, 1'b0, 16'h0080, "b_step7");
    cyc(1, 1'b0, 1'b1, M_UP, 4'd0, 4'd7, 1'b1, 1'b0, 16'h0080, "b_ps1b");
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1'b0, 1'b0, M_UP, 4'd0, 4'd7, 1'b1, 1'b0, 16'h0080, "b_frozen");
    end
    cyc(1, 1'b0, 1'b1, M_UP, 4'd0, 4'd7, 1'b1, 1'b0, 16'h0080, "b_ps2b");
    cyc(1, 1'b0, 1'b1, M_UP, 4'd0, 4'd0, 1'b1, 1'b1, 16'h0001, "b_wrap");
    cyc(1, 1'b0, 1'b0, M_UP, 4'd0, 4'd0, 1'b1, 1'b0, 16'h0001, "b_en0_wrap_clr");
    cyc(1, 1'b0, 1'b1, M_UP, 4'd0, 4'd0, 1'b1, 1'b0, 16'h0001, "b_ps1c");

    // Instance C: active-low, 4-bit index
    cyc(2, 1'b1, 1'b1, M_HOLD, 4'd0, 4'd0, 1'b0, 1'b0, 16'hFFFF, "c_rst");
    cyc(2, 1'b0, 1'b1, M_LOAD, 4'd9, 4'd9, 1'b1, 1'b0, 16'hFDFF, "c_load9");
    cyc(2, 1'b0, 1'b1, M_UP, 4'd0, 4'd9, 1'b1, 1'b0, 16'hFDFF, "c_entry");
    cyc(2, 1'b0, 1'b1, M_UP, 4'd0, 4'd10, 1'b1, 1'b0, 16'hFBFF, "c_step");

    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
